// File: rtl/part_err_sched_if.sv
// Handshake and result bundle between the error scheduler and the exact/approximate partitions.
// The master side drives start/abort and the partition responses; the slave is the scheduler.
interface part_err_sched_if #(
  parameter int unsigned NIN  = 7,
  parameter int unsigned NOUT = 4
) ();
  localparam int unsigned HamW = NIN + $clog2(NOUT) + 1;

  logic            start;
  logic            abort;
  logic [NIN-1:0]  vec_out;
  logic [NOUT-1:0] exact_in;
  logic [NOUT-1:0] approx_in;
  logic            busy;
  logic            done;
  logic [NIN:0]    mism_cnt;
  logic [HamW-1:0] ham_sum;
  logic [NOUT-1:0] max_err;

  modport master (
    output start, abort, exact_in, approx_in,
    input  vec_out, busy, done, mism_cnt, ham_sum, max_err
  );

  modport slave (
    input  start, abort, exact_in, approx_in,
    output vec_out, busy, done, mism_cnt, ham_sum, max_err
  );
endinterface

// File: rtl/part_err_sched.sv
// Exhaustive-sweep error scheduler: walks every input vector of a partition and accumulates
// mismatch count, Hamming sum and max absolute error of the approximate versus exact response.
module part_err_sched #(
  parameter int unsigned NIN  = 7,
  parameter int unsigned NOUT = 4
) (
  input logic              clk,
  input logic              rst,
  part_err_sched_if.slave  bus
);
  localparam int unsigned HamW = NIN + $clog2(NOUT) + 1;
  localparam int unsigned PcW  = $clog2(NOUT + 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [NIN-1:0]  vec_q, vec_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_mism_q, s1_mism_d;
  logic [PcW-1:0]  s1_pop_q, s1_pop_d;
  logic [NOUT-1:0] s1_abs_q, s1_abs_d;
  logic [NIN:0]    mism_q, mism_d;
  logic [HamW-1:0] ham_q, ham_d;
  logic [NOUT-1:0] max_q, max_d;
  logic [NOUT-1:0] diff;
  logic            launch, sweeping;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StSweep;
      StSweep: begin
        if (bus.abort)       state_d = StIdle;
        else if (&vec_q)     state_d = StDrain;
      end
      StDrain: state_d = bus.abort ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StSweep) || (state_q == StDrain);
    bus.done = (state_q == StDone);
  end

  // Stage 1 captures per-vector error terms; stage 2 folds them into the accumulators.
  always_comb begin
    launch   = (state_q == StIdle) && bus.start;
    sweeping = (state_q == StSweep) && !bus.abort;
    diff     = bus.exact_in ^ bus.approx_in;

    s1_valid_d = sweeping;
    s1_mism_d  = |diff;
    s1_pop_d   = '0;
    for (int i = 0; i < int'(NOUT); i++) begin
      s1_pop_d = s1_pop_d + PcW'(diff[i]);
    end
    s1_abs_d = (bus.exact_in >= bus.approx_in) ? (bus.exact_in - bus.approx_in)
                                               : (bus.approx_in - bus.exact_in);

    vec_d = vec_q;
    if (launch)        vec_d = '0;
    else if (sweeping) vec_d = vec_q + NIN'(1);

    mism_d = mism_q;
    ham_d  = ham_q;
    max_d  = max_q;
    if (launch) begin
      mism_d = '0;
      ham_d  = '0;
      max_d  = '0;
    end else if (s1_valid_q) begin
      mism_d = mism_q + (NIN + 1)'(s1_mism_q);
      ham_d  = ham_q + HamW'(s1_pop_q);
      max_d  = (s1_abs_q > max_q) ? s1_abs_q : max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_mism_q  <= 1'b0;
      s1_pop_q   <= '0;
      s1_abs_q   <= '0;
      mism_q     <= '0;
      ham_q      <= '0;
      max_q      <= '0;
    end else begin
      vec_q      <= vec_d;
      s1_valid_q <= s1_valid_d;
      s1_mism_q  <= s1_mism_d;
      s1_pop_q   <= s1_pop_d;
      s1_abs_q   <= s1_abs_d;
      mism_q     <= mism_d;
      ham_q      <= ham_d;
      max_q      <= max_d;
    end
  end

  assign bus.vec_out  = vec_q;
  assign bus.mism_cnt = mism_q;
  assign bus.ham_sum  = ham_q;
  assign bus.max_err  = max_q;
endmodule

// File: tb/tb_part_err_sched.sv
// Directed bench for part_err_sched: a cycle-position model of the sweep predicts every output
// each cycle, and literal expectations pin the final and partial results of each scenario.
module tb_part_err_sched;
  localparam int unsigned NIN  = 7;
  localparam int unsigned NOUT = 4;
  localparam int          NVEC = 1 << NIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  part_err_sched_if #(.NIN(NIN), .NOUT(NOUT)) bus ();

  part_err_sched #(.NIN(NIN), .NOUT(NOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  bit chk_en = 1'b0;

  // 0: approx equals exact, 1: approx is zero, 2: approx keeps only the upper two bits
  function automatic logic [3:0] f_approx(int m, logic [NIN-1:0] v);
    case (m)
      0:       return v[3:0];
      1:       return 4'd0;
      default: return v[3:0] & 4'b1100;
    endcase
  endfunction

  always_comb begin
    bus.exact_in  = bus.vec_out[3:0];
    bus.approx_in = f_approx(mode, bus.vec_out);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos is the cycle index within a run (0 = idle, 1..NVEC sweep, NVEC+1 drain,
  // NVEC+2 done). Results visible in cycle p cover vectors 0..p-3.
  int m_pos = 0;
  int m_mism = 0, m_ham = 0, m_max = 0;
  bit m_vec_known = 1'b1;

  task automatic model_acc(input int v);
    logic [NIN-1:0] vv;
    int e, a, d;
    vv = NIN'(v);
    e  = int'(vv[3:0]);
    a  = int'(f_approx(mode, vv));
    d  = (e > a) ? e - a : a - e;
    if (e != a) m_mism++;
    m_ham += $countones(e ^ a);
    if (d > m_max) m_max = d;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_mism = 0; m_ham = 0; m_max = 0; m_vec_known = 1'b1;
    end else if (m_pos == 0) begin
      if (bus.start) begin
        m_pos = 1; m_mism = 0; m_ham = 0; m_max = 0; m_vec_known = 1'b1;
      end
    end else if (m_pos == NVEC + 2) begin
      m_pos = 0;
    end else begin
      if (m_pos >= 2) model_acc(m_pos - 2);
      if (bus.abort) begin
        m_pos = 0;
        m_vec_known = 1'b0;
      end else begin
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_pos >= 1 && m_pos <= NVEC + 1));
      check("done", 64'(bus.done), 64'(m_pos == NVEC + 2));
      if (m_vec_known)
        check("vec_out", 64'(bus.vec_out), 64'((m_pos >= 1 && m_pos <= NVEC) ? m_pos - 1 : 0));
      check("mism_cnt", 64'(bus.mism_cnt), 64'(m_mism));
      check("ham_sum", 64'(bus.ham_sum), 64'(m_ham));
      check("max_err", 64'(bus.max_err), 64'(m_max));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is high during the current cycle (cycle 0); returns in cycle 1.
  task automatic launch(input int m);
    mode = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!bus.done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_results(input string tag, input int mc, input int hs, input int me);
    check({tag, ".mism_cnt"}, 64'(bus.mism_cnt), 64'(mc));
    check({tag, ".ham_sum"}, 64'(bus.ham_sum), 64'(hs));
    check({tag, ".max_err"}, 64'(bus.max_err), 64'(me));
  endtask

  task automatic count_dones(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      tick();
      if (bus.done) dn++;
    end
  endtask

  initial begin
    int c, dn;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.vec_out", 64'(bus.vec_out), 64'd0);
    check_results("rst", 0, 0, 0);
    rst = 1'b0;
    tick();

    // Identical partitions
    launch(0);
    wait_done(1, c);
    check("exact.done_cycle", 64'(c), 64'd130);
    check_results("exact", 0, 0, 0);
    tick();

    // approx = 0, with ignored starts at cycle 10 and in the done cycle
    launch(1);
    repeat (9) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(11, c);
    check("zero.done_cycle", 64'(c), 64'd130);
    check_results("zero", 120, 256, 15);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero.start_in_done.busy", 64'(bus.busy), 64'd0);
    check_results("zero.hold", 120, 256, 15);
    count_dones(5, dn);
    check("zero.extra_done", 64'(dn), 64'd0);

    // approx keeps upper bits
    launch(2);
    wait_done(1, c);
    check("mask.done_cycle", 64'(c), 64'd130);
    check_results("mask", 96, 128, 3);
    tick();

    // Abort at cycle 50: vectors 0..48 accumulated
    launch(1);
    repeat (49) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort50.busy", 64'(bus.busy), 64'd0);
    check_results("abort50", 45, 96, 15);
    count_dones(140, dn);
    check("abort50.no_done", 64'(dn), 64'd0);
    launch(1);
    wait_done(1, c);
    check("rerun.done_cycle", 64'(c), 64'd130);
    check_results("rerun", 120, 256, 15);
    tick();

    // Abort in the drain cycle: final vector folded in, no done
    launch(1);
    repeat (128) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_drain.busy", 64'(bus.busy), 64'd0);
    check("abort_drain.done", 64'(bus.done), 64'd0);
    check_results("abort_drain", 120, 256, 15);
    tick();

    // Start and abort together in idle: start wins
    mode = 2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort.busy", 64'(bus.busy), 64'd1);
    wait_done(1, c);
    check("start_abort.done_cycle", 64'(c), 64'd130);
    check_results("start_abort", 96, 128, 3);
    tick();

    // Reset at cycle 60
    launch(1);
    repeat (59) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst60.busy", 64'(bus.busy), 64'd0);
    check("rst60.done", 64'(bus.done), 64'd0);
    check("rst60.vec_out", 64'(bus.vec_out), 64'd0);
    check_results("rst60", 0, 0, 0);
    count_dones(140, dn);
    check("rst60.no_done", 64'(dn), 64'd0);

    // Reset dominates start
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check("rst_start.busy", 64'(bus.busy), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/part_err_sched.md
PART_ERR_SCHED -- requirements
Module: part_err_sched

Interface
REQ-001 Parameter NIN, default 7, number of partition inputs; sweep length 2^NIN vectors.
REQ-002 Parameter NOUT, default 4, number of partition outputs; bit 0 (po0) is LSB.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  sampled in IDLE only; launches one exhaustive sweep.
REQ-006 abort  input  1  terminates a sweep in progress.
REQ-007 vec_out  output  NIN  registered stimulus word, driven to exact and approximate partition inputs (pi0 = bit 0).
REQ-008 exact_in  input  NOUT  combinational response of exact partition to vec_out, same cycle.
REQ-009 approx_in  input  NOUT  combinational response of approximate (BMF-factored) partition to vec_out, same cycle.
REQ-010 busy  output  1  high in SWEEP and DRAIN.
REQ-011 done  output  1  one-cycle pulse when results are final.
REQ-012 mism_cnt  output  NIN+1  count of vectors with exact_in != approx_in.
REQ-013 ham_sum  output  NIN+clog2(NOUT)+1  sum of popcount(exact_in ^ approx_in) over all vectors.
REQ-014 max_err  output  NOUT  maximum of |exact_in - approx_in|, operands unsigned.

Function
REQ-015 The FSM SHALL have states IDLE, SWEEP, DRAIN, DONE.
REQ-016 IDLE + start=1 -> SWEEP; vec_out=0, mism_cnt, ham_sum and max_err cleared on the same edge.
REQ-017 In SWEEP, vec_out SHALL increment by 1 each cycle; vec_out = 2^NIN-1 -> DRAIN next cycle, vec_out wraps to 0.
REQ-018 Stage 1: at the end of each SWEEP cycle, the block SHALL register diff-valid, mismatch flag, popcount of XOR and absolute difference for the current vec_out.
REQ-019 Stage 2: one cycle later, registered stage-1 values SHALL be accumulated: mism_cnt += flag, ham_sum += popcount, max_err = max(max_err, absdiff).
REQ-020 DRAIN lasts exactly 1 cycle and accumulates the final vector; DRAIN -> DONE.
REQ-021 DONE lasts 1 cycle with done=1, busy=0; DONE -> IDLE unconditionally.
REQ-022 With start at cycle 0: SWEEP occupies cycles 1..2^NIN, DRAIN 2^NIN+1, done at 2^NIN+2 (130 for NIN=7).
REQ-023 Result outputs SHALL hold stable from done until next accepted start.
REQ-024 start outside IDLE (including DONE cycle) SHALL be ignored.
REQ-025 abort=1 in SWEEP or DRAIN -> IDLE next edge; no done pulse; stage-1 valid cleared; results keep partial values.
REQ-026 abort and start in the same IDLE cycle: start wins; abort in IDLE/DONE has no effect.
REQ-027 Accumulators SHALL not saturate or wrap; widths per REQ-012/013 cover the worst case (128, 512 for defaults).

Reset
REQ-028 rst=1 SHALL force, on the next edge, state IDLE, vec_out=0, busy=0, done=0, mism_cnt=0, ham_sum=0, max_err=0, stage-1 valid=0.
REQ-029 rst SHALL dominate start and abort; reset mid-sweep aborts with no done pulse.

Verification
REQ-030 approx_in=exact_in=vec_out[3:0], start at cycle 0 -> done at cycle 130, mism_cnt=0, ham_sum=0, max_err=0.
REQ-031 exact_in=vec_out[3:0], approx_in=0 -> mism_cnt=120, ham_sum=256, max_err=15.
REQ-032 exact_in=vec_out[3:0], approx_in=vec_out[3:0]&4'b1100 -> mism_cnt=96, ham_sum=128, max_err=3.
REQ-033 abort at cycle 50 of a REQ-031 sweep -> busy=0 at cycle 51, no done; subsequent start yields full REQ-031 results.
REQ-034 start pulsed at cycles 10 and 130 of a sweep -> ignored, single done at 130; rst at cycle 60 -> all outputs 0 at cycle 61, no done.
